// File: rtl/debounce_pulse.sv
// Pushbutton conditioner: synchronizer, debounce counter and 4-state FSM giving a one-cycle pulse and a debounced level.
// Optional auto-repeat while held is enabled by defining DEBOUNCE_AUTOREPEAT_EN.
module debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic clock,
  input  logic nReset,
  input  logic button_n,
  output logic pulse,
  output logic level
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam longint CNT_CAP = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reject configurations the counter cannot represent at elaboration time.
  if (DEBOUNCE_CYCLES < 2 ||
      longint'(DEBOUNCE_CYCLES) > CNT_CAP ||
      longint'(REPEAT_DELAY) > CNT_CAP ||
      longint'(REPEAT_PERIOD) > CNT_CAP) begin : g_bad_params
    $error("debounce_pulse: illegal DEBOUNCE_CYCLES/REPEAT_*/CNT_W combination");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             sync2;
  logic             pressed_s;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rcnt;
  logic             repeating;
  logic [CNT_W-1:0] rlimit;

  assign rlimit = repeating ? RP_LAST : RD_LAST;
`endif

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= button_n;
      sync2 <= sync1;
    end
  end

  assign pressed_s = ~sync2;

  // Counters stop at their terminal value or saturate; they never wrap.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      rcnt      <= '0;
      repeating <= 1'b0;
`endif
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!pressed_s) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state <= HELD;
            pulse <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rcnt      <= '0;
            repeating <= 1'b0;
`endif
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        HELD: begin
          if (!pressed_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rcnt      <= '0;
            repeating <= 1'b0;
          end else if (rcnt == rlimit) begin
            pulse     <= 1'b1;
            rcnt      <= '0;
            repeating <= 1'b1;
          end else if (rcnt != CNT_MAX) begin
            rcnt <= rcnt + 1'b1;
`endif
          end
        end

        RELEASE_WAIT: begin
          if (pressed_s) begin
            state <= HELD;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            level <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboard bench for debounce_pulse: expected pulse timestamps are queued per stimulus and matched to observed pulses.
// Auto-repeat expectations follow DEBOUNCE_AUTOREPEAT_EN when the bench is built with it.
module tb_debounce_pulse;

  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  // Button driven at a falling edge stamped t; pulse visible at the falling edge stamped t + DB + 3.
  localparam int LAT = DB + 3;

  logic clock = 1'b0;
  logic nReset = 1'b0;
  logic button_n = 1'b1;
  logic pulse;
  logic level;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int obs_q[$];
  logic [3:0] count;

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .CNT_W(25)
  ) dut (
    .clock(clock),
    .nReset(nReset),
    .button_n(button_n),
    .pulse(pulse),
    .level(level)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) if (pulse) obs_q.push_back(cyc);

  always @(posedge clock or negedge nReset) begin
    if (!nReset) count <= 4'd0;
    else if (pulse) count <= count + 4'd1;
  end

  // t_exit is the stamp at which the FSM has left HELD; repeats strictly before it are expected.
  function automatic void push_press(int t_start, int t_exit);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    int p;
`endif
    exp_q.push_back(t_start + LAT);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    p = t_start + LAT + RD;
    while (p < t_exit) begin
      exp_q.push_back(p);
      p += RP;
    end
`else
    if (t_exit < 0) exp_q.push_back(-1);
`endif
  endfunction

  task automatic test_reset();
    nReset = 1'b0;
    button_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_pulse: got %b want 0", pulse);
    end
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_level: got %b want 0", level);
    end
    nReset = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_clean_press();
    int t0;
    int e;
    int o;
    logic want;
    @(negedge clock);
    button_n = 1'b0;
    t0 = cyc;
    push_press(t0, t0 + 23);
    for (int k = 0; k < 34; k++) begin
      @(negedge clock);
      want = (cyc >= t0 + LAT) && (cyc < t0 + 20 + LAT);
      checks++;
      if (level !== want) begin
        errors++;
        $display("[TB] FAIL clean_level: got %b want %b at stamp %0d", level, want, cyc - t0);
      end
      if (cyc == t0 + 20) button_n = 1'b1;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL clean_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL clean_pulse_time: got %0d want %0d", o - t0, e - t0);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_bounce();
    int t0;
    int e;
    int o;
    logic want;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      button_n = i[0];
      repeat (2) begin
        @(negedge clock);
        checks++;
        if (level !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bounce_level: got %b want 0 during bounce", level);
        end
      end
    end
    button_n = 1'b0;
    t0 = cyc;
    push_press(t0, t0 + 15);
    for (int k = 0; k < 26; k++) begin
      @(negedge clock);
      want = (cyc >= t0 + LAT) && (cyc < t0 + 12 + LAT);
      checks++;
      if (level !== want) begin
        errors++;
        $display("[TB] FAIL bounce_level_steady: got %b want %b at stamp %0d", level, want, cyc - t0);
      end
      if (cyc == t0 + 12) button_n = 1'b1;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL bounce_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL bounce_pulse_time: got %0d want %0d", o - t0, e - t0);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_release_glitch();
    int t0;
    int e;
    int o;
    logic want;
    @(negedge clock);
    button_n = 1'b0;
    t0 = cyc;
    // HELD is first left at t0+13; after re-entry the repeat wait restarts and cannot fire before release.
    push_press(t0, t0 + 13);
    for (int k = 0; k < 34; k++) begin
      @(negedge clock);
      want = (cyc >= t0 + LAT) && (cyc < t0 + 18 + LAT);
      checks++;
      if (level !== want) begin
        errors++;
        $display("[TB] FAIL glitch_level: got %b want %b at stamp %0d", level, want, cyc - t0);
      end
      if (cyc == t0 + 10) button_n = 1'b1;
      if (cyc == t0 + 12) button_n = 1'b0;
      if (cyc == t0 + 18) button_n = 1'b1;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL glitch_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL glitch_pulse_time: got %0d want %0d", o - t0, e - t0);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int d;
    int e;
    int o;
    logic want;
    @(negedge clock);
    button_n = 1'b0;
    repeat (4) @(negedge clock);
    nReset = 1'b0;
    #1;
    checks++;
    if (pulse !== 1'b0 || level !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_wait: got pulse=%b level=%b want 0/0", pulse, level);
    end
    repeat (2) @(negedge clock);
    nReset = 1'b1;
    d = cyc;
    push_press(d, d + 10);
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      want = (cyc >= d + LAT);
      checks++;
      if (level !== want) begin
        errors++;
        $display("[TB] FAIL reset_mid_level: got %b want %b at stamp %0d", level, want, cyc - d);
      end
    end
    nReset = 1'b0;
    #1;
    checks++;
    if (pulse !== 1'b0 || level !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_held: got pulse=%b level=%b want 0/0", pulse, level);
    end
    button_n = 1'b1;
    repeat (2) @(negedge clock);
    nReset = 1'b1;
    repeat (12) @(negedge clock);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL reset_mid_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid_pulse_time: got %0d want %0d", o - d, e - d);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_autorepeat();
    int t0;
    int e;
    int o;
    logic want;
    @(negedge clock);
    button_n = 1'b0;
    t0 = cyc;
    push_press(t0, t0 + LAT + 28 + 3);
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      want = (cyc >= t0 + LAT) && (cyc < t0 + LAT + 28 + LAT);
      checks++;
      if (level !== want) begin
        errors++;
        $display("[TB] FAIL repeat_level: got %b want %b at stamp %0d", level, want, cyc - t0);
      end
      if (cyc == t0 + LAT + 28) button_n = 1'b1;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL repeat_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL repeat_pulse_time: got %0d want %0d", o - t0, e - t0);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_counter();
    int t0;
    int e;
    int o;
    logic [3:0] want;
    @(negedge clock);
    nReset = 1'b0;
    @(negedge clock);
    nReset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      button_n = 1'b0;
      t0 = cyc;
      push_press(t0, t0 + 11);
      for (int k = 0; k < 20; k++) begin
        @(negedge clock);
        if (cyc == t0 + 8) button_n = 1'b1;
      end
      want = 4'((i + 1) % 16);
      checks++;
      if (count !== want) begin
        errors++;
        $display("[TB] FAIL counter_value: got %0d want %0d after press %0d", count, want, i + 1);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("[TB] FAIL counter_pulse_count: got %0d want %0d on press %0d", obs_q.size(), exp_q.size(), i + 1);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL counter_pulse_time: got %0d want %0d on press %0d", o - t0, e - t0, i + 1);
        end
      end
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_reset_mid();
    test_autorepeat();
    test_counter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
